// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - host request/response, memory FSM and counter signals of mem_access_ctrl
interface mem_access_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [2:0] mem_a;
  logic [7:0] mem_inp;
  logic       mem_op;
  logic       mem_select;
  logic       mem_valid;
  logic [7:0] mem_out;
  logic [7:0] txn_count;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_valid, mem_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_inp, mem_op,
           mem_select, txn_count
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_valid, mem_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_inp, mem_op,
           mem_select, txn_count
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request memory access sequencer with timeout and response hold
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC  = 8,
  parameter bit INVERT_RDATA = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_RESP   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

  state_t     r_state;
  state_t     w_next;
  logic       r_we;
  logic [2:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_wait_cnt;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_err;
  logic [7:0] r_txn_count;

  logic       w_accept;
  logic [7:0] w_wait_inc;
  logic       w_timeout;
  logic [7:0] w_read_data;

  assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
  assign w_wait_inc  = r_wait_cnt + 8'd1;
  assign w_timeout   = (w_wait_inc == TO_LIMIT);
  assign w_read_data = INVERT_RDATA ? ~bus.mem_out : bus.mem_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.req_valid) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (bus.mem_valid || w_timeout) w_next = S_RESP;
      S_RESP:   if (bus.rsp_ready) w_next = S_GAP;
      S_GAP:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Latched request doubles as the memory-side drive, so it holds through RESP/GAP/IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we        <= 1'b0;
      r_addr      <= 3'd0;
      r_wdata     <= 8'd0;
      r_wait_cnt  <= 8'd0;
      r_rsp_rdata <= 8'd0;
      r_rsp_err   <= 1'b0;
      r_txn_count <= 8'd0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (r_state == S_SETUP) begin
        r_wait_cnt <= 8'd0;
      end else if (r_state == S_ACCESS) begin
        r_wait_cnt <= w_wait_inc;
      end
      // mem_valid is checked first so a response on the final wait cycle still succeeds.
      if (r_state == S_ACCESS) begin
        if (bus.mem_valid) begin
          r_rsp_rdata <= r_we ? 8'd0 : w_read_data;
          r_rsp_err   <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_rdata <= 8'd0;
          r_rsp_err   <= 1'b1;
        end
      end
      if ((r_state == S_RESP) && bus.rsp_ready) begin
        r_txn_count <= r_txn_count + 8'd1;
      end
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE) && reset;
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.mem_a      = r_addr;
  assign bus.mem_inp    = r_wdata;
  assign bus.mem_op     = r_we;
  assign bus.mem_select = (r_state == S_ACCESS);
  assign bus.txn_count  = r_txn_count;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed vector bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT_CYC(8), .INVERT_RDATA(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    int         delay;
    logic [7:0] mem_out;
    int         bp;
    logic       early;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_sel;
  } vec_t;

  vec_t       vecs [7];
  int         n_vec = 0;
  int         n_fail = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_txn(input vec_t v);
    int sel;
    int lat;
    int budget;
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = ~v.we;
    bus.req_addr  = ~v.addr;
    bus.req_wdata = ~v.wdata;
    chk("setup_select", bus.mem_select, 0);
    chk("setup_req_ready", bus.req_ready, 0);
    chk("setup_mem_a", bus.mem_a, v.addr);
    chk("setup_mem_inp", bus.mem_inp, v.wdata);
    chk("setup_mem_op", bus.mem_op, v.we);
    bus.mem_out   = v.mem_out;
    bus.rsp_ready = v.early;
    sel = 0;
    budget = 0;
    @(negedge clk);
    lat = 2;
    while (!bus.rsp_valid && budget < 40) begin
      if (bus.mem_select) begin
        sel++;
        bus.mem_valid = (sel == v.delay);
      end
      @(negedge clk);
      lat++;
      budget++;
    end
    bus.mem_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("rsp_seen", bus.rsp_valid, 1);
    chk("select_cycles", sel, v.exp_sel);
    chk("latency", lat, 2 + v.exp_sel);
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    chk("rsp_err", bus.rsp_err, v.exp_err);
    chk("resp_select", bus.mem_select, 0);
    chk("resp_req_ready", bus.req_ready, 0);
    chk("resp_mem_a_hold", bus.mem_a, v.addr);
    chk("resp_mem_inp_hold", bus.mem_inp, v.wdata);
    chk("resp_txn_count", bus.txn_count, exp_cnt);
    for (int i = 0; i < v.bp; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 3'(i);
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_rdata", bus.rsp_rdata, v.exp_rdata);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("gap_rsp_valid", bus.rsp_valid, 0);
    chk("gap_select", bus.mem_select, 0);
    chk("gap_req_ready", bus.req_ready, 0);
    chk("gap_txn_count", bus.txn_count, exp_cnt);
    @(negedge clk);
    chk("idle_again", bus.req_ready, 1);
    chk("idle_mem_a_hold", bus.mem_a, v.addr);
    chk("idle_mem_op_hold", bus.mem_op, v.we);
  endtask

  initial begin
    vec_t w;
    //         we    addr  wdata  dly mem_out bp early rdata  err sel
    vecs[0] = '{1'b1, 3'd0, 8'd65, 2, 8'h00, 0, 1'b0, 8'h00, 1'b0, 2};
    vecs[1] = '{1'b0, 3'd1, 8'h00, 1, 8'hAC, 0, 1'b0, 8'h53, 1'b0, 1};
    vecs[2] = '{1'b0, 3'd4, 8'h00, 0, 8'h5A, 0, 1'b0, 8'h00, 1'b1, 8};
    vecs[3] = '{1'b0, 3'd7, 8'h00, 8, 8'h0F, 0, 1'b0, 8'hF0, 1'b0, 8};
    vecs[4] = '{1'b0, 3'd2, 8'h00, 3, 8'h00, 5, 1'b0, 8'hFF, 1'b0, 3};
    vecs[5] = '{1'b1, 3'd5, 8'hFF, 9, 8'h33, 2, 1'b1, 8'h00, 1'b1, 8};
    vecs[6] = '{1'b0, 3'd3, 8'h00, 1, 8'hFF, 0, 1'b1, 8'h00, 1'b0, 1};

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 3'd0;
    bus.req_wdata = 8'd0;
    bus.rsp_ready = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_out   = 8'd0;

    repeat (2) @(negedge clk);
    chk("rst_select", bus.mem_select, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_inp", bus.mem_inp, 0);
    chk("rst_mem_op", bus.mem_op, 0);
    chk("rst_txn_count", bus.txn_count, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1);

    for (int k = 0; k < 7; k++) do_txn(vecs[k]);

    // Reset in the middle of ACCESS must drop select without a clock edge.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 3'd6;
    bus.req_wdata = 8'h99;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pre_select", bus.mem_select, 1);
    chk("midrst_pre_count", bus.txn_count, 7);
    reset = 1'b0;
    #1;
    chk("midrst_select", bus.mem_select, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_txn_count", bus.txn_count, 0);
    chk("midrst_mem_a", bus.mem_a, 0);
    chk("midrst_mem_op", bus.mem_op, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", bus.rsp_valid, 0);
    end
    chk("midrst_idle", bus.req_ready, 1);
    chk("midrst_count_after", bus.txn_count, 0);

    for (int i = 0; i < 256; i++) begin
      w = '{1'b1, 3'(i), 8'(i), 1, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1};
      do_txn(w);
    end
    chk("wrap_zero", bus.txn_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
